// File: rtl/mem_bist_master.sv
// mem_bist_master: fill-and-verify BIST initiator for the memory valid/ready
// interface. A start pulse writes pat(a) = SEED + a*STRIDE to every address,
// then reads everything back and counts mismatches. The results are pass,
// err_count and the first failing address.
// Optional ready watchdog: define MEM_BIST_TIMEOUT_EN to add the `timeout` output.
module mem_bist_master #(
    parameter int          DEPTH      = 64,
    parameter int          ADDR_WIDTH = $clog2(DEPTH),
    parameter int          WIDTH      = 16,
    parameter logic [15:0] SEED       = 16'h1234,
    parameter logic [15:0] STRIDE     = 16'h0101,
    parameter int          TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_rd,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  valid,
    input  logic                  ready
`ifdef MEM_BIST_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = {(ADDR_WIDTH + 1){1'b1}};

    // Test pattern for an address, wrapped to WIDTH bits.
    function automatic logic [WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        logic [WIDTH-1:0] seed_w;
        logic [WIDTH-1:0] stride_w;
        logic [WIDTH-1:0] a_w;
        seed_w   = WIDTH'(SEED);
        stride_w = WIDTH'(STRIDE);
        a_w      = WIDTH'(a);
        return seed_w + a_w * stride_w;
    endfunction

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wr_rd_r;
    logic [WIDTH-1:0]      wdata_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  pass_r;
    logic [ADDR_WIDTH:0]   err_count_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;

    logic                  hs_s;
    logic                  last_s;
    logic                  mismatch_s;
    logic [ADDR_WIDTH-1:0] addr_inc_s;
    logic [ADDR_WIDTH:0]   err_next_s;
    logic                  to_s;

    // Handshake, end-of-range and the saturating error count after this compare.
    always_comb begin
        hs_s       = valid_r & ready;
        last_s     = (addr_r == LAST_ADDR);
        addr_inc_s = addr_r + ADDR_WIDTH'(1'b1);
        mismatch_s = (rdata != pat(addr_r));
        if (mismatch_s) begin
            if (err_count_r == ERR_MAX) begin
                err_next_s = err_count_r;
            end else begin
                err_next_s = err_count_r + (ADDR_WIDTH + 1)'(1'b1);
            end
        end else begin
            err_next_s = err_count_r;
        end
    end

`ifdef MEM_BIST_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_r;

    // Fire when this stall cycle would be the TIMEOUT-th in a row.
    always_comb begin
        to_s = valid_r & ~ready & (wait_cnt_r == WAIT_W'(TIMEOUT - 1));
    end

    // Count consecutive stalled cycles; any handshake or idle bus restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (!valid_r || ready) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
        end
    end

    // Sticky timeout flag, cleared when a new test is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            timeout_r <= 1'b0;
        end else if (to_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    assign to_s = 1'b0;

    // Without the watchdog the master waits for ready indefinitely.
    if (TIMEOUT < 0) begin : g_no_watchdog
    end
`endif

    // Main sequencer: fill, verify, report; all interface outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            wr_rd_r     <= 1'b0;
            wdata_r     <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= '0;
            fail_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= WRITE;
                        addr_r      <= '0;
                        wr_rd_r     <= 1'b1;
                        wdata_r     <= pat('0);
                        valid_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        err_count_r <= '0;
                        fail_addr_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (hs_s) begin
                        if (last_s) begin
                            state_r <= READ;
                            addr_r  <= '0;
                            wr_rd_r <= 1'b0;
                            wdata_r <= '0;
                        end else begin
                            addr_r  <= addr_inc_s;
                            wdata_r <= pat(addr_inc_s);
                        end
                    end else if (to_s) begin
                        state_r <= DONE;
                        valid_r <= 1'b0;
                        addr_r  <= '0;
                        wr_rd_r <= 1'b0;
                        wdata_r <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b0;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                READ: begin
                    if (hs_s) begin
                        err_count_r <= err_next_s;
                        if (mismatch_s && err_count_r == '0) begin
                            fail_addr_r <= addr_r;
                        end else begin
                            fail_addr_r <= fail_addr_r;
                        end
                        if (last_s) begin
                            state_r <= DONE;
                            valid_r <= 1'b0;
                            addr_r  <= '0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == '0);
                        end else begin
                            addr_r  <= addr_inc_s;
                        end
                    end else if (to_s) begin
                        state_r <= DONE;
                        valid_r <= 1'b0;
                        addr_r  <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b0;
                    end else begin
                        state_r <= READ;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign fail_addr = fail_addr_r;
    assign addr      = addr_r;
    assign wr_rd     = wr_rd_r;
    assign wdata     = wdata_r;
    assign valid     = valid_r;

endmodule

// File: tb/tb_mem_bist_master.sv
// Testbench for mem_bist_master: behavioural memory responder with
// configurable stalls and read-bit corruption. It applies a vector table plus
// hand sequences for reset, start-while-busy and, with MEM_BIST_TIMEOUT_EN, timeout.
module tb_mem_bist_master;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int W     = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic [AW-1:0] addr;
    logic          wr_rd;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          valid;
    logic          ready;
`ifdef MEM_BIST_TIMEOUT_EN
    logic          timeout;
`endif

    mem_bist_master #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WIDTH(W),
        .SEED(16'h1234), .STRIDE(16'h0101), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
        .addr(addr), .wr_rd(wr_rd), .wdata(wdata), .rdata(rdata),
        .valid(valid), .ready(ready)
`ifdef MEM_BIST_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  mem [DEPTH];
    int            wr_cnt [DEPTH];
    int            rd_cnt = 0;
    int            stall_cfg = 0;
    int            stall_cnt = 0;
    int            fa = -1;
    int            fb = -1;
    bit            never_ready = 1'b0;
    bit            h_valid = 1'b0;
    logic [AW-1:0] h_addr;
    logic          h_wr;
    logic [W-1:0]  h_wdata;
    logic [W-1:0]  w5;

    typedef struct {
        int stall;
        int fa;
        int fb;
        bit exp_pass;
        int exp_err;
        int exp_fail;
        int exp_cyc;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [W-1:0] pat_m(input int a);
        int v;
        v = 32'h1234 + a * 32'h0101;
        return v[15:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: decides ready for the coming posedge, supplies rdata, and
    // records the transfer that will complete there; checks holds during stalls.
    always @(negedge clk) begin
        if (rst && valid) begin
            if (h_valid) begin
                chk("hold_addr", addr, h_addr);
                chk("hold_wr_rd", wr_rd, h_wr);
                chk("hold_wdata", wdata, h_wdata);
            end
            if (!never_ready && stall_cnt >= stall_cfg) begin
                ready = 1'b1;
                if (wr_rd) begin
                    chk("wdata_pattern", wdata, pat_m(int'(addr)));
                    mem[addr] = wdata;
                    wr_cnt[addr]++;
                    if (addr == 6'd5) w5 = wdata;
                    rdata = '0;
                end else begin
                    rdata = mem[addr] ^ (((int'(addr) == fa) || (int'(addr) == fb)) ? 16'h0001 : 16'h0000);
                    rd_cnt++;
                end
                stall_cnt = 0;
                h_valid   = 1'b0;
            end else begin
                ready     = 1'b0;
                stall_cnt++;
                h_valid   = 1'b1;
                h_addr    = addr;
                h_wr      = wr_rd;
                h_wdata   = wdata;
            end
        end else begin
            ready     = 1'b0;
            stall_cnt = 0;
            h_valid   = 1'b0;
        end
    end

    task automatic prep(input int stall, input int a, input int b);
        stall_cfg   = stall;
        fa          = a;
        fb          = b;
        never_ready = 1'b0;
        rd_cnt      = 0;
        w5          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = ~pat_m(i);
            wr_cnt[i] = 0;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic post_start_checks();
        chk("start_busy", busy, 1);
        chk("start_valid", valid, 1);
        chk("start_wr_rd", wr_rd, 1);
        chk("start_addr", addr, 0);
        chk("start_wdata", wdata, 16'h1234);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err_count, 0);
        chk("start_fail_clr", fail_addr, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int bad;
        prep(v.stall, v.fa, v.fb);
        start_pulse();
        post_start_checks();
        wait_done(n);
        chk("cycles", n, v.exp_cyc);
        chk("pass", pass, v.exp_pass);
        chk("err_count", err_count, v.exp_err);
        chk("fail_addr", fail_addr, v.exp_fail);
        chk("done_busy", busy, 0);
        chk("done_valid", valid, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_cnt[i] != 1) bad++;
        end
        chk("write_once", bad, 0);
        chk("read_count", rd_cnt, DEPTH);
        chk("wdata_addr5", w5, 16'h1739);
        @(posedge clk);
        #1;
        chk("done_sticky", done, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n;

        vecs[0] = '{stall: 0, fa: -1, fb: -1, exp_pass: 1'b1, exp_err: 0, exp_fail: 0,  exp_cyc: 128};
        vecs[1] = '{stall: 3, fa: -1, fb: -1, exp_pass: 1'b1, exp_err: 0, exp_fail: 0,  exp_cyc: 512};
        vecs[2] = '{stall: 0, fa: 10, fb: 40, exp_pass: 1'b0, exp_err: 2, exp_fail: 10, exp_cyc: 128};
        vecs[3] = '{stall: 1, fa: 63, fb: -1, exp_pass: 1'b0, exp_err: 1, exp_fail: 63, exp_cyc: 256};
        vecs[4] = '{stall: 0, fa: 0,  fb: -1, exp_pass: 1'b0, exp_err: 1, exp_fail: 0,  exp_cyc: 128};

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        rdata = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail", fail_addr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_rd", wr_rd, 0);
        chk("rst_wdata", wdata, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of the write phase.
        prep(0, -1, -1);
        start_pulse();
        n = 0;
        while (!(valid && wr_rd && addr == 6'd20) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_addr20", addr, 20);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_wr_rd", wr_rd, 0);
        chk("midrst_wdata", wdata, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_pass", pass, 0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0]);

        // Start while busy (READ of addr 7), then start during the DONE cycle.
        prep(0, -1, -1);
        start_pulse();
        n = 0;
        while (!(valid && !wr_rd && addr == 6'd7) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_read7", addr, 7);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_busy", busy, 1);
        chk("busy_start_addr", addr, 8);
        chk("busy_start_wr_rd", wr_rd, 0);
        wait_done(n);
        chk("busy_start_cycles", n, 56);
        chk("busy_start_pass", pass, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_start_busy", busy, 0);
        chk("done_start_valid", valid, 0);
        chk("done_start_done", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("after_done_busy", busy, 0);
        chk("after_done_done", done, 1);
        chk("read_count_busy", rd_cnt, DEPTH);

`ifdef MEM_BIST_TIMEOUT_EN
        // Responder never accepts: watchdog must end the test.
        prep(0, -1, -1);
        never_ready = 1'b1;
        start_pulse();
        wait_done(n);
        chk("to_cycles", n, 255);
        chk("to_flag", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_valid", valid, 0);
        chk("to_busy", busy, 0);
        never_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
